// File: rtl/aes_spi_host.sv
// rtl/aes_spi_host.sv - SPI host that loads an AES peripheral with {plaintext,key} and reads back the result
// Optional build macro AES_SPI_HOST_TIMEOUT_EN bounds the wait for done by TIMEOUT_CYCLES.
module aes_spi_host #(
    parameter int CLK_DIV        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         ready,
    output logic         sck,
    output logic         sdi,
    input  logic         sdo,
    output logic         load,
    input  logic         done,
    output logic [127:0] cyphertext,
    output logic         valid,
    output logic         err
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_SETUP,
        SHIFT_IN,
        LOAD_DROP,
        WAIT_DONE,
        SHIFT_OUT,
        RESULT,
        ERROR
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t       state, state_n;
    logic [7:0]   div_cnt, div_cnt_n;
    logic [7:0]   bit_cnt, bit_cnt_n;
    logic         sck_q, sck_n;
    logic         load_q, load_n;
    logic [255:0] shreg, shreg_n;
    logic [127:0] ct_q, ct_n;
    logic         div_end;

    assign div_end = (div_cnt == DIV_LAST);

`ifdef AES_SPI_HOST_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            to_expired;

    assign to_expired = (to_cnt == TO_LAST);
`endif

    // The outgoing frame shifts zeros in behind it, so shreg[255] reads 0 once the
    // frame is sent; readout then reuses the low half of the same register.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        sck_n     = sck_q;
        load_n    = load_q;
        shreg_n   = shreg;
        ct_n      = ct_q;
`ifdef AES_SPI_HOST_TIMEOUT_EN
        to_cnt_n  = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD_SETUP;
                    shreg_n   = {plaintext, key};
                    load_n    = 1'b1;
                    sck_n     = 1'b0;
                    div_cnt_n = 8'd0;
                    bit_cnt_n = 8'd0;
                end
            end
            LOAD_SETUP: begin
                if (div_end) begin
                    sck_n     = 1'b1;
                    div_cnt_n = 8'd0;
                    state_n   = SHIFT_IN;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            SHIFT_IN: begin
                if (!div_end) begin
                    div_cnt_n = div_cnt + 8'd1;
                end else begin
                    div_cnt_n = 8'd0;
                    if (!sck_q) begin
                        sck_n = 1'b1;
                    end else begin
                        sck_n   = 1'b0;
                        shreg_n = {shreg[254:0], 1'b0};
                        if (bit_cnt == 8'd255) begin
                            bit_cnt_n = 8'd0;
                            state_n   = LOAD_DROP;
                        end else begin
                            bit_cnt_n = bit_cnt + 8'd1;
                        end
                    end
                end
            end
            LOAD_DROP: begin
                if (div_end) begin
                    load_n    = 1'b0;
                    div_cnt_n = 8'd0;
                    state_n   = WAIT_DONE;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_n   = SHIFT_OUT;
                    div_cnt_n = 8'd0;
                    bit_cnt_n = 8'd0;
                end
`ifdef AES_SPI_HOST_TIMEOUT_EN
                else if (to_expired) begin
                    state_n = ERROR;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
`endif
            end
            SHIFT_OUT: begin
                // Readout starts with a low half-period; sdo is taken on each rise.
                if (!div_end) begin
                    div_cnt_n = div_cnt + 8'd1;
                end else begin
                    div_cnt_n = 8'd0;
                    if (!sck_q) begin
                        sck_n   = 1'b1;
                        shreg_n = {shreg[254:0], sdo};
                    end else begin
                        sck_n = 1'b0;
                        if (bit_cnt == 8'd127) begin
                            bit_cnt_n = 8'd0;
                            ct_n      = shreg[127:0];
                            state_n   = RESULT;
                        end else begin
                            bit_cnt_n = bit_cnt + 8'd1;
                        end
                    end
                end
            end
            RESULT:  state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 8'd0;
            sck_q   <= 1'b0;
            load_q  <= 1'b0;
            shreg   <= '0;
            ct_q    <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            sck_q   <= sck_n;
            load_q  <= load_n;
            shreg   <= shreg_n;
            ct_q    <= ct_n;
        end
    end

`ifdef AES_SPI_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_n;
        end
    end

    assign err = (state == ERROR);
`else
    // No timeout hardware: err is a constant low.
    assign err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    assign ready      = (state == IDLE);
    assign valid      = (state == RESULT);
    assign sck        = sck_q;
    assign load       = load_q;
    assign sdi        = shreg[255];
    assign cyphertext = ct_q;

endmodule

// File: tb/tb_aes_spi_host.sv
// tb/tb_aes_spi_host.sv - scoreboard bench for aes_spi_host with a behavioural AES peripheral
`timescale 1ns/1ps
module tb_aes_spi_host;
    localparam int CLK_DIV        = 2;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         ready;
    logic         sck;
    logic         sdi;
    logic         sdo = 1'b0;
    logic         load;
    logic         done = 1'b0;
    logic [127:0] cyphertext;
    logic         valid;
    logic         err;

    always #5 clk = ~clk;

    aes_spi_host #(
        .CLK_DIV        (CLK_DIV),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .ready      (ready),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .load       (load),
        .done       (done),
        .cyphertext (cyphertext),
        .valid      (valid),
        .err        (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic logic [127:0] lookup(input logic [255:0] f);
        if (f == {PT_A, KEY_A}) return CT_A;
        if (f == {PT_B, KEY_B}) return CT_B;
        return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
    endfunction

    // Scoreboard: expected results queued at start, compared on every valid.
    logic [127:0] exp_q[$];
    logic         valid_prev = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            check("mon", "valid_width", 128'(valid_prev), 128'd0);
            if (exp_q.size() == 0) check("mon", "unexpected_valid", 128'd1, 128'd0);
            else check("mon", "cyphertext", cyphertext, exp_q.pop_front());
        end
        valid_prev = valid;
    end

    // Behavioural peripheral plus bus statistics.
    int           cyc = 0;
    logic         sck_p = 1'b0;
    logic         load_p = 1'b0;
    logic [255:0] frame = '0;
    int           in_rises = 0;
    int           out_rises = 0;
    int           last_fall_cyc = 0;
    int           load_fall_cyc = 0;
    int           err_cnt = 0;
    int           err_cyc = 0;
    int           valid_cnt = 0;
    bit           respond = 1'b1;
    int           done_dly = 0;
    int           dly_cnt = -1;
    logic [127:0] resp = '0;
    bit           reading = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            done    = 1'b0;
            sdo     = 1'b0;
            reading = 1'b0;
            dly_cnt = -1;
        end else begin
            if (load && !load_p) begin
                frame     = '0;
                in_rises  = 0;
                out_rises = 0;
            end
            if (load && sck && !sck_p) begin
                frame = {frame[254:0], sdi};
                in_rises++;
            end
            if (load && !sck && sck_p) last_fall_cyc = cyc;
            if (!load && load_p) begin
                load_fall_cyc = cyc;
                if (respond) dly_cnt = done_dly;
            end
            if (dly_cnt == 0) begin
                resp      = lookup(frame);
                done      = 1'b1;
                sdo       = resp[127];
                reading   = 1'b1;
                out_rises = 0;
            end
            if (dly_cnt >= 0) dly_cnt--;
            if (reading && !load && sck && !sck_p) begin
                out_rises++;
                done = 1'b0;
            end
            if (reading && !load && !sck && sck_p) begin
                if (out_rises == 128) begin
                    reading = 1'b0;
                    sdo     = 1'b0;
                end else begin
                    resp = {resp[126:0], 1'b0};
                    sdo  = resp[127];
                end
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (valid) valid_cnt++;
        end
        sck_p  = sck;
        load_p = load;
    end

    logic [127:0] last_ct = '0;

    task automatic run_txn(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int dly, input int glitch_at, input int reset_at, input string tag);
        bit glitched = 1'b0;
        bit ok = 1'b0;
        done_dly = dly;
        @(negedge clk);
        check(tag, "ready_before", 128'(ready), 128'd1);
        key       = k;
        plaintext = pt;
        start     = 1'b1;
        if (reset_at == 0) exp_q.push_back(exp_ct);
        @(negedge clk);
        start = 1'b0;
        check(tag, "ready_drop", 128'(ready), 128'd0);
        check(tag, "ct_held", cyphertext, last_ct);
        for (int i = 0; i < 6000; i++) begin
            if (glitch_at > 0 && !glitched && in_rises == glitch_at) begin
                key       = KEY_A;
                plaintext = PT_A;
                start     = 1'b1;
                glitched  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (reset_at > 0 && in_rises == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                check(tag, "rst_sck", 128'(sck), 128'd0);
                check(tag, "rst_load", 128'(load), 128'd0);
                check(tag, "rst_ready", 128'(ready), 128'd1);
                check(tag, "rst_ct", cyphertext, 128'd0);
                @(negedge clk);
                reset   = 1'b0;
                last_ct = '0;
                return;
            end
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check(tag, "completes", 128'(ok), 128'd1);
        if (ok) last_ct = exp_ct;
    endtask

    initial begin
        int err0;
        int val0;
        bit ok;
        reset     = 1'b1;
        start     = 1'b0;
        key       = '0;
        plaintext = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset", "ready", 128'(ready), 128'd1);
        check("reset", "sck", 128'(sck), 128'd0);
        check("reset", "load", 128'(load), 128'd0);
        check("reset", "sdi", 128'(sdi), 128'd0);
        check("reset", "valid", 128'(valid), 128'd0);
        check("reset", "err", 128'(err), 128'd0);
        check("reset", "ct", cyphertext, 128'd0);

        run_txn(KEY_A, PT_A, CT_A, 5, 0, 0, "txnA");
        check("txnA", "in_rises", 128'(in_rises), 128'd256);
        check("txnA", "frame_hi", frame[255:128], PT_A);
        check("txnA", "frame_lo", frame[127:0], KEY_A);
        check("txnA", "rises1_8", 128'(frame[255:248]), 128'd0);
        check("txnA", "rises129_136", 128'(frame[127:120]), 128'd0);
        check("txnA", "load_fall_gap", 128'(load_fall_cyc - last_fall_cyc), 128'(CLK_DIV));
        check("txnA", "out_rises", 128'(out_rises), 128'd128);

        run_txn(KEY_B, PT_B, CT_B, 0, 50, 0, "txnB_glitch");
        check("txnB_glitch", "frame", frame[127:0], KEY_B);
        check("txnB_glitch", "in_rises", 128'(in_rises), 128'd256);

        run_txn(KEY_A, PT_A, CT_A, 2, 0, 0, "txnA_new_key");
        check("txnA_new_key", "frame", frame[127:0], KEY_A);

        run_txn(KEY_A, PT_A, CT_A, 2, 0, 100, "rst100");
        run_txn(KEY_B, PT_B, CT_B, 1, 0, 0, "after_rst");
        check("after_rst", "out_rises", 128'(out_rises), 128'd128);

        respond = 1'b0;
        err0    = err_cnt;
        val0    = valid_cnt;
        @(negedge clk);
        key       = KEY_A;
        plaintext = PT_A;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
`ifdef AES_SPI_HOST_TIMEOUT_EN
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("timeout", "ready_returns", 128'(ok), 128'd1);
        check("timeout", "err_width", 128'(err_cnt - err0), 128'd1);
        check("timeout", "err_delay", 128'(err_cyc - load_fall_cyc), 128'(TIMEOUT_CYCLES));
        check("timeout", "no_valid", 128'(valid_cnt - val0), 128'd0);
        check("timeout", "ct_kept", cyphertext, last_ct);
`else
        repeat (1500) @(negedge clk);
        check("timeout", "ready_stays_low", 128'(ready), 128'd0);
        check("timeout", "no_err", 128'(err_cnt - err0), 128'd0);
        check("timeout", "no_valid", 128'(valid_cnt - val0), 128'd0);
        check("timeout", "ct_kept", cyphertext, last_ct);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("timeout", "ready_after_reset", 128'(ready), 128'd1);
`endif
        respond = 1'b1;
        check("final", "scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_spi_host.md
AES_SPI_HOST -- requirements
Module: aes_spi_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning sck half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the clk-cycle limit for waiting on done (used only under REQ-030).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a transaction; sampled only while ready=1.
REQ-006 SHALL have port key, input, 128 bits: AES key, captured on the accepted start.
REQ-007 SHALL have port plaintext, input, 128 bits: AES plaintext, captured on the accepted start.
REQ-008 SHALL have port ready, output, 1 bit: host idle and able to accept start.
REQ-009 SHALL have port sck, output, 1 bit: SPI clock, mode 0 (idles low).
REQ-010 SHALL have port sdi, output, 1 bit: serial data to the AES peripheral.
REQ-011 SHALL have port sdo, input, 1 bit: serial data from the AES peripheral.
REQ-012 SHALL have port load, output, 1 bit: peripheral load strobe.
REQ-013 SHALL have port done, input, 1 bit: peripheral encryption-complete flag.
REQ-014 SHALL have port cyphertext, output, 128 bits: last received result.
REQ-015 SHALL have port valid, output, 1 bit: one-cycle pulse when cyphertext updates.
REQ-016 SHALL have port err, output, 1 bit: one-cycle timeout pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_SETUP, SHIFT_IN, LOAD_DROP, WAIT_DONE, SHIFT_OUT, RESULT, and ERROR.
REQ-018 In IDLE, ready=1; start=1 SHALL capture {plaintext,key} into a 256-bit shift register, drop ready, and enter LOAD_SETUP on the next cycle.
REQ-019 A start asserted while ready=0 SHALL be ignored, with no queuing.
REQ-020 LOAD_SETUP SHALL drive load=1 and sdi=plaintext[127], and hold sck low for CLK_DIV cycles before the first rising edge.
REQ-021 Each bit SHALL be sck high for CLK_DIV cycles then low for CLK_DIV cycles; sdi SHALL change only in the cycle where sck falls.
REQ-022 SHIFT_IN SHALL produce exactly 256 rising edges, sending plaintext[127..0] then key[127..0], MSB first.
REQ-023 After the 256th falling edge, LOAD_DROP SHALL keep sck=0 for CLK_DIV cycles, then deassert load and set sdi=0.
REQ-024 WAIT_DONE SHALL sample done every clk cycle; the first cycle with done=1 SHALL start SHIFT_OUT after CLK_DIV low cycles, including when done is already high on entry.
REQ-025 SHIFT_OUT SHALL produce exactly 128 sck pulses with sdi=0, sampling sdo in the clk cycle in which sck rises, assembled MSB first.
REQ-026 After the 128th falling edge, RESULT SHALL load cyphertext and pulse valid for exactly 1 cycle, then return to IDLE (ready=1 on the next cycle).
REQ-027 cyphertext SHALL hold its value until the next RESULT; it is not cleared on start.
REQ-028 load SHALL be constant for the whole of SHIFT_IN, and sck SHALL be 0 whenever load changes.

Reset
REQ-029 reset=1 SHALL, at the next posedge clk from any state including mid-shift, force IDLE and set sck=0, sdi=0, load=0, valid=0, err=0, ready=1, and cyphertext=0; all internal counters SHALL clear.

Configuration
REQ-030 Macro AES_SPI_HOST_TIMEOUT_EN: when defined, a counter SHALL run in WAIT_DONE; if TIMEOUT_CYCLES cycles elapse without done, the FSM SHALL enter ERROR, pulse err for 1 cycle, leave cyphertext unchanged with valid=0, and return to IDLE. When not defined, WAIT_DONE SHALL wait indefinitely, err SHALL be tied 0, and no counter SHALL be synthesized.

Verification
REQ-031 Reset: assert reset 1 cycle mid-idle -> ready=1, sck=load=sdi=valid=err=0, cyphertext=0.
REQ-032 Bit order, CLK_DIV=2: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff -> exactly 256 sck rises while load=1; sdi at rises 1..8 = 0; sdi at rises 129..136 = 00000000; load falls 2 cycles after the last sck fall.
REQ-033 End-to-end with the AES peripheral on the same clk, same vectors -> cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a, valid high for exactly 1 cycle, 128 readout sck pulses.
REQ-034 start pulsed during SHIFT_IN with different key -> ignored; a subsequent start after ready returns uses the new key, and its result matches the reference model.
REQ-035 reset asserted at the 100th sck rise of SHIFT_IN -> next cycle sck=0, load=0, ready=1; a following full transaction is correct.
REQ-036 With the macro defined, TIMEOUT_CYCLES=16, and done held 0 -> err pulses 1 cycle 16 cycles after entering WAIT_DONE, valid stays 0, and ready returns; with the macro undefined -> err never asserts and ready stays 0.
